// File: rtl/rom_stream_reader.sv
// Streams a contiguous, modulo-2**ADDR_W run of bytes from a 1-cycle-latency synchronous ROM
// to a valid/ready consumer, absorbing the read latency with a small FIFO.
//
// state  | meaning
// IDLE   | waiting for start; first address is issued on the accepting edge
// RUN    | issuing addresses and draining the buffer
// FINISH | one-cycle done pulse
module rom_stream_reader #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     issue_cnt;
    logic                v1, v2;
    logic [DATA_W-1:0]   buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    buf_count;
    logic [OCC_W-1:0]    occ;
    logic                push, pop, issue, start_run, last_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push    = v2;
    assign m_valid = (buf_count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);

    // Occupancy counts in-flight reads so a stalled consumer can never overflow the buffer.
    assign occ = OCC_W'(buf_count) + OCC_W'(v1) + OCC_W'(v2) - OCC_W'(pop);
    assign last_pop = (buf_count == '0) || ((buf_count == CNT_W'(1)) && pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        start_run  = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            RUN: begin
                issue = (issue_cnt < len_r) && (occ < OCC_W'(BUF_DEPTH));
                if ((issue_cnt == len_r) && !v1 && !v2 && last_pop)
                    state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r    <= '0;
            len_r     <= '0;
            issue_cnt <= '0;
            rom_addr  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            if (start_run) begin
                base_r    <= base_addr;
                len_r     <= len;
                rom_addr  <= base_addr;
                issue_cnt <= (ADDR_W+1)'(1);
            end else if (issue) begin
                rom_addr  <= base_r + issue_cnt[ADDR_W-1:0];
                issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
            end
            // v1 tracks rom_addr, v2 tracks rom_data; stale re-reads stay unmarked
            v1 <= start_run || issue;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr] <= rom_data;
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a registered-read ROM model holding ROM[i] = i[7:0].
module tb_rom_stream_reader;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy, done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] acc_q [$];
    logic [DATA_W-1:0] rom_mem [2**ADDR_W];

    rom_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i);

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    always @(posedge clk) begin
        if (!reset && m_valid && m_ready) acc_q.push_back(m_data);
        if (!reset && done) done_cnt++;
    end

    task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        #12;
        checks += 5;
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        if (rom_addr !== 9'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic stream_check(input string name, input logic [ADDR_W-1:0] b, input int n, input bit chk_addr);
        int d0;
        logic [DATA_W-1:0] exp_d;
        logic [ADDR_W-1:0] exp_a;
        d0 = done_cnt;
        m_ready = 1'b1;
        launch(b, (ADDR_W+1)'(n));
        for (int k = 0; k <= n + 3; k++) begin
            checks += 3;
            if (m_valid !== (k >= 2 && k < n + 2)) begin
                failures++; $display("FAIL %s_m_valid k=%0d got=%b", name, k, m_valid);
            end
            if (done !== (k == n + 2)) begin
                failures++; $display("FAIL %s_done k=%0d got=%b", name, k, done);
            end
            if (busy !== (k <= n + 2)) begin
                failures++; $display("FAIL %s_busy k=%0d got=%b", name, k, busy);
            end
            if (k >= 2 && k < n + 2) begin
                exp_d = DATA_W'(int'(b) + k - 2);
                checks++;
                if (m_data !== exp_d) begin
                    failures++; $display("FAIL %s_m_data k=%0d got=%h exp=%h", name, k, m_data, exp_d);
                end
            end
            if (chk_addr && k < n) begin
                exp_a = ADDR_W'(int'(b) + k);
                checks++;
                if (rom_addr !== exp_a) begin
                    failures++; $display("FAIL %s_rom_addr k=%0d got=%0d exp=%0d", name, k, rom_addr, exp_a);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt - d0);
        end
    endtask

    task automatic test_basic;
        stream_check("basic", 9'h010, 4, 1'b1);
    endtask

    task automatic test_wrap;
        stream_check("wrap", 9'd510, 4, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [39:0] pat;
        bit seen, prev_stall;
        logic [DATA_W-1:0] prev_data;
        int ahead;
        pat = 40'b1000_0000_0011_0110_0000_0001_1100_0000_0101_1111;
        acc_q.delete();
        m_ready = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        seen = 1'b0;
        launch(9'd0, 10'd16);
        for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
            if (done) seen = 1'b1;
            if (busy && !done) begin
                ahead = int'(rom_addr) + 1 - acc_q.size();
                checks++;
                if (ahead > BUF_DEPTH) begin
                    failures++; $display("FAIL bp_ahead cyc=%0d got=%0d max=%0d", cyc, ahead, BUF_DEPTH);
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    failures++; $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h", cyc, m_valid, m_data, prev_data);
                end
            end
            m_ready    = pat[cyc % 40];
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++;
        if (acc_q.size() !== 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", acc_q.size()); end
        for (int i = 0; i < 16 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== DATA_W'(i)) begin
                failures++; $display("FAIL bp_byte i=%0d got=%h exp=%h", i, acc_q[i], DATA_W'(i));
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_restart_ignored;
        bit seen;
        acc_q.delete();
        m_ready = 1'b1;
        launch(9'h020, 10'd3);
        @(negedge clk);
        base_addr = 9'h080; len = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_until_done(50, seen);
        checks += 2;
        if (!seen) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
        if (acc_q.size() !== 3) begin failures++; $display("FAIL restart_count got=%0d exp=3", acc_q.size()); end
        for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== DATA_W'(8'h20 + i)) begin
                failures++; $display("FAIL restart_byte i=%0d got=%h exp=%h", i, acc_q[i], DATA_W'(8'h20 + i));
            end
        end
        @(negedge clk);
        acc_q.delete();
        launch(9'h030, 10'd2);
        run_until_done(50, seen);
        checks += 2;
        if (!seen) begin failures++; $display("FAIL second_timeout got=no_done exp=done"); end
        if (acc_q.size() !== 2 || acc_q[0] !== 8'h30 || acc_q[1] !== 8'h31) begin
            failures++; $display("FAIL second_bytes got_n=%0d exp=30,31", acc_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_len0;
        logic [ADDR_W-1:0] a0;
        a0 = rom_addr;
        launch(9'h055, 10'd0);
        checks += 4;
        if (busy !== 1'b1)    begin failures++; $display("FAIL len0_busy got=%b exp=1", busy); end
        if (done !== 1'b1)    begin failures++; $display("FAIL len0_done got=%b exp=1", done); end
        if (m_valid !== 1'b0) begin failures++; $display("FAIL len0_m_valid got=%b exp=0", m_valid); end
        if (rom_addr !== a0)  begin failures++; $display("FAIL len0_rom_addr got=%0d exp=%0d", rom_addr, a0); end
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0)    begin failures++; $display("FAIL len0_busy_end got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL len0_done_end got=%b exp=0", done); end
        if (m_valid !== 1'b0) begin failures++; $display("FAIL len0_m_valid_end got=%b exp=0", m_valid); end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        int d0;
        acc_q.delete();
        m_ready = 1'b1;
        launch(9'd0, 10'd32);
        for (int i = 0; i < 100 && acc_q.size() < 5; i++) @(negedge clk);
        checks++;
        if (acc_q.size() !== 5) begin failures++; $display("FAIL abort_reach got=%0d exp=5", acc_q.size()); end
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1;
        checks += 5;
        if (busy !== 1'b0)     begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0)     begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        if (m_valid !== 1'b0)  begin failures++; $display("FAIL abort_m_valid got=%b exp=0", m_valid); end
        if (m_data !== 8'h00)  begin failures++; $display("FAIL abort_m_data got=%h exp=00", m_data); end
        if (rom_addr !== 9'd0) begin failures++; $display("FAIL abort_rom_addr got=%0d exp=0", rom_addr); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got_done=%0d busy=%b exp=0,0", done_cnt - d0, busy);
        end
        acc_q.delete();
        launch(9'h100, 10'd2);
        run_until_done(50, seen);
        checks += 2;
        if (!seen) begin failures++; $display("FAIL post_abort_timeout got=no_done exp=done"); end
        if (acc_q.size() !== 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'h01) begin
            failures++; $display("FAIL post_abort_bytes got_n=%0d exp=00,01", acc_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_restart_ignored();
        test_len0();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequencer that sits directly in front of the 512x8 synchronous ROM. It drives the ROM address, absorbs the ROM's 1-cycle read latency, and streams a contiguous run of bytes to a downstream consumer (e.g. UART TX FIFO, display writer) over a valid/ready handshake.
- A run is set by a base address and a length. Addresses wrap modulo 512.
- Sustains 1 byte/cycle while the consumer is ready. No byte is lost or duplicated under backpressure.

Parameters:
- ADDR_W, 9, ROM address width; ROM depth is 2**ADDR_W.
- DATA_W, 8, ROM/stream data width.
- BUF_DEPTH, 4, output buffer entries; must be >= 3 to sustain full rate.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- base_addr  input  ADDR_W  first ROM address of the run; captured with start.
- len  input  ADDR_W+1  byte count, 0..512; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the run completes.
- rom_addr  output  ADDR_W  registered address to the ROM.
- rom_data  input  DATA_W  ROM read data; valid 1 cycle after rom_addr.
- m_data  output  DATA_W  stream byte (head of output buffer).
- m_valid  output  1  m_data valid.
- m_ready  input  1  consumer accepts m_data this cycle.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, m_valid=0, m_data=0, rom_addr=0, buffer emptied, in-flight tracking cleared, counters cleared.
- FSM has three states: IDLE, RUN, FINISH.
  - IDLE + start with len>0: capture base_addr/len, go to RUN.
  - IDLE + start with len=0: go to FINISH with no ROM read.
  - RUN to FINISH: after the last address has been issued, the last byte has been written to the buffer, and that byte has been accepted (m_valid&&m_ready).
  - FINISH: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and FINISH. start is ignored whenever busy=1.
- Issue rule (RUN): issue when issue_cnt < len AND (buf_count + in_flight - pop) < BUF_DEPTH.
  - pop = m_valid && m_ready.
  - in_flight counts issued addresses whose data has not yet been written to the buffer; it ranges 0..2.
- On issue: rom_addr <= (base + issue_cnt) mod 2**ADDR_W. Wrap is plain truncation, e.g. 511 -> 0.
- When not issuing, rom_addr holds its value. The resulting extra ROM reads are discarded.
- Read pipeline: an address registered at edge E reaches the ROM data output at E+1 and is written to the buffer at E+2.
- Capture uses a 2-stage valid shift register aligned to rom_addr, so only issued addresses are written.
- Latency: start sampled at edge E0 gives rom_addr=base after E0, and m_valid=1 with m_data=ROM[base] after E2.
- Output buffer is FIFO ordered. m_valid = (buf_count>0).
- m_data stays stable while m_valid=1 and m_ready=0.
- A simultaneous write and pop in the same cycle keeps buf_count unchanged.
- Throughput: with m_ready held high, one byte per cycle with no bubbles after the first. A len-byte run completes in len+2 cycles after start, and done pulses the cycle after that.
- Backpressure: with m_ready low, issue stops once buf_count+in_flight reaches BUF_DEPTH. Buffered and in-flight data are retained. Overflow is impossible by construction.
- Counters are ADDR_W+1 bits so that len=512 reads all 512 locations exactly once.
- Reset mid-run aborts immediately: buffered bytes are dropped and no done pulse is produced.

Test Plan:
- ROM preloaded with ROM[i]=i[7:0]; start, base=0x010, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; first m_valid 2 cycles after start; single done pulse; busy returns to 0.
- base=510, len=4, m_ready=1 -> rom_addr sequence 510,511,0,1; m_data 0xFE,0xFF,0x00,0x01.
- base=0, len=16, m_ready toggled randomly with long low stretches -> exactly 16 accepted bytes 0x00..0x0F in order; rom_addr never more than BUF_DEPTH ahead of accepted count; m_data stable while stalled.
- start pulsed again mid-run with different base/len -> ignored; original run completes unchanged; a new start after done is accepted.
- len=0 start -> no m_valid, done pulses 1 cycle later, busy high for exactly that span.
- Reset asserted asynchronously between clock edges mid-run (base=0, len=32, after 5 bytes) -> outputs go to reset values immediately, no done; a subsequent run with base=0x100, len=2 (ROM[0x100]=0x00, ROM[0x101]=0x01) streams 0x00,0x01 correctly.
